// File: rtl/ofifo_psum.sv
// Output FIFO bank below the MAC array: one FIFO per column, written with skewed
// column valids, popped as a full row once every column holds data.

module ofifo_col #(
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] din,
  input  logic               wr,
  input  logic               rd_acc,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);
  localparam int AW = $clog2(depth);

  logic [psum_bw-1:0] mem [depth];
  logic [AW:0]        wptr, rptr;
  logic               wr_acc;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  // a row pop in the same cycle frees the slot, so a full column may still accept
  assign wr_acc = wr & (~full | rd_acc);
  assign drop   = wr & full & ~rd_acc;
  assign dout   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + (AW+1)'(1);
      if (rd_acc) rptr <= rptr + (AW+1)'(1);
    end
  end

  // push-at-full overwrites the slot being popped; the pop reads the old value
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem[wptr[AW-1:0]] <= din;
  end
endmodule

module ofifo_psum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);
  logic [col-1:0]              empty, full, drop;
  logic [col-1:0][psum_bw-1:0] dout;
  logic                        rd_acc;

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign rd_acc  = rd & o_valid;

  for (genvar gi = 0; gi < col; gi++) begin : g_col
    ofifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk    (clk),
      .reset  (reset),
      .din    (in[psum_bw*gi +: psum_bw]),
      .wr     (wr[gi]),
      .rd_acc (rd_acc),
      .dout   (dout[gi]),
      .empty  (empty[gi]),
      .full   (full[gi]),
      .drop   (drop[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (rd_acc) out <= dout;
      if (|drop)  o_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ofifo_psum.sv
// Directed bench for ofifo_psum: queue-based row model checked every cycle,
// plus literal expectations for each scenario.

module tb_ofifo_psum;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int DEPTH = 64;
  localparam int W = COL*PBW;

  logic           clk = 0;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid, o_full, o_ready, o_overflow;

  ofifo_psum #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // model: per-column queues, behaviour from the acceptance rules
  logic [PBW-1:0] q [COL][$];
  logic [W-1:0]   m_out;
  logic           m_ovf, m_valid, m_full;

  task automatic model_step();
    bit racc, all_ne;
    all_ne = 1;
    for (int i = 0; i < COL; i++) if (q[i].size() == 0) all_ne = 0;
    if (!reset) begin
      for (int i = 0; i < COL; i++) q[i].delete();
      m_out = '0;
      m_ovf = 0;
    end else begin
      bit was_full [COL];
      racc = rd && all_ne;
      for (int i = 0; i < COL; i++) was_full[i] = (q[i].size() == DEPTH);
      if (racc)
        for (int i = 0; i < COL; i++) m_out[PBW*i +: PBW] = q[i].pop_front();
      for (int i = 0; i < COL; i++)
        if (wr[i]) begin
          if (!was_full[i] || racc) q[i].push_back(in[PBW*i +: PBW]);
          else m_ovf = 1;
        end
    end
    m_valid = 1;
    m_full = 0;
    for (int i = 0; i < COL; i++) begin
      if (q[i].size() == 0) m_valid = 0;
      if (q[i].size() == DEPTH) m_full = 1;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("out", out, m_out);
    chk("o_valid", W'(o_valid), W'(m_valid));
    chk("o_full", W'(o_full), W'(m_full));
    chk("o_ready", W'(o_ready), W'(!m_full));
    chk("o_overflow", W'(o_overflow), W'(m_ovf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rep(logic [PBW-1:0] v);
    return {COL{v}};
  endfunction

  task automatic do_reset();
    reset = 0; wr = '0; rd = 0; in = '0;
    step(); step();
    reset = 1;
  endtask

  initial begin
    logic [W-1:0] v;
    reset = 0; wr = '0; rd = 0; in = '0;
    step();
    chk_en = 1;

    // 1: reset and idle
    step();
    reset = 1;
    step();
    chk("t1_out", out, '0);
    chk("t1_valid", W'(o_valid), W'(0));
    chk("t1_full", W'(o_full), W'(0));
    chk("t1_ready", W'(o_ready), W'(1));
    chk("t1_ovf", W'(o_overflow), W'(0));

    // 2: skewed fill with rd held high
    rd = 1;
    for (int i = 0; i < COL; i++) begin
      wr = COL'(1) << i;
      in = '0;
      in[PBW*i +: PBW] = PBW'(16'h0100 + i);
      step();
      if (i < COL-1) chk("t2_valid_early", W'(o_valid), W'(0));
    end
    wr = '0;
    chk("t2_valid_rise", W'(o_valid), W'(1));
    chk("t2_out_held", out, '0);
    step();
    for (int i = 0; i < COL; i++) v[PBW*i +: PBW] = PBW'(16'h0100 + i);
    chk("t2_row", out, v);
    chk("t2_valid_after", W'(o_valid), W'(0));
    rd = 0;

    // 3: order across pointer wrap, occupancy held at 1
    do_reset();
    wr = '1; in = rep(16'd0);
    step();
    rd = 1;
    for (int k = 1; k < 3*DEPTH; k++) begin
      in = rep(PBW'(k));
      step();
      chk("t3_order", out, rep(PBW'(k-1)));
      chk("t3_nofull", W'(o_full), W'(0));
    end
    wr = '0;
    step();
    chk("t3_last", out, rep(PBW'(3*DEPTH-1)));
    rd = 0;

    // 4: fill column 3, overflow, then drain
    do_reset();
    wr = 8'h08;
    for (int k = 0; k < DEPTH; k++) begin
      in = '0; in[PBW*3 +: PBW] = PBW'(16'h3000 + k);
      step();
    end
    chk("t4_full", W'(o_full), W'(1));
    chk("t4_ready", W'(o_ready), W'(0));
    in[PBW*3 +: PBW] = 16'hDEAD;
    step();
    chk("t4_ovf", W'(o_overflow), W'(1));
    wr = 8'hF7;
    for (int k = 0; k < DEPTH; k++) begin
      in = rep(PBW'(k));
      step();
    end
    wr = '0; rd = 1;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("t4_col3", W'(out[PBW*3 +: PBW]), W'(16'h3000 + k));
    end
    rd = 0;
    step();
    chk("t4_empty", W'(o_valid), W'(0));

    // 5: push and pop at full
    do_reset();
    wr = '1;
    for (int k = 0; k < DEPTH; k++) begin
      in = rep(PBW'(k));
      step();
    end
    chk("t5_valid", W'(o_valid), W'(1));
    chk("t5_full", W'(o_full), W'(1));
    rd = 1; in = rep(16'hBEEF);
    step();
    wr = '0;
    chk("t5_full_kept", W'(o_full), W'(1));
    chk("t5_no_ovf", W'(o_overflow), W'(0));
    chk("t5_first", out, rep(16'd0));
    for (int k = 1; k < DEPTH; k++) step();
    chk("t5_before", out, rep(PBW'(DEPTH-1)));
    step();
    chk("t5_beef", out, rep(16'hBEEF));
    rd = 0;

    // 6: reset mid-operation
    do_reset();
    wr = '1;
    for (int k = 0; k < 5; k++) begin
      in = rep(PBW'(16'h0A00 + k));
      step();
    end
    rd = 1; in = rep(16'h1234);
    step();
    reset = 0;
    step();
    reset = 1; rd = 0; wr = '0;
    chk("t6_valid", W'(o_valid), W'(0));
    chk("t6_out", out, '0);
    chk("t6_ovf", W'(o_overflow), W'(0));
    wr = '1; in = rep(16'h55AA);
    step();
    wr = '0; rd = 1;
    step();
    rd = 0;
    chk("t6_new", out, rep(16'h55AA));
    chk("t6_drained", W'(o_valid), W'(0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ofifo_psum.md
Name: ofifo_psum

Overview:
- Output FIFO bank directly downstream of the MAC array.
- Captures the per-column partial sums leaving the south edge of the array. Column valids arrive skewed by one cycle per column.
- Releases a full row (all columns) to the accumulation/SFU stage once every column holds data.
- One independent FIFO per column, with a common read port.

Parameters:
- col, 8, number of array columns (independent FIFOs).
- psum_bw, 16, partial-sum width per column.
- depth, 64, entries per column FIFO; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- in  input  col*psum_bw  column psums; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
- wr  input  col  per-column write valid (from the array's south-edge valid).
- rd  input  1  read request for one full row.
- out  output  col*psum_bw  registered row data, same packing as in.
- o_valid  output  1  every column FIFO is non-empty, so a read is possible.
- o_full  output  1  at least one column FIFO is full.
- o_ready  output  1  equals ~o_full.
- o_overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Storage per column: depth×psum_bw array plus write/read pointers of log2(depth)+1 bits; the extra bit is the wrap bit.
  - empty_i = (wptr_i == rptr_i).
  - full_i = (low bits equal) and (wrap bits differ).
- Reset (reset==0 at a clk edge):
  - All pointers go to 0; out=0, o_overflow=0.
  - Consequently o_valid=0, o_full=0, o_ready=1.
  - Storage contents are don't-care.
  - Reset wins over any simultaneous wr/rd. Reset mid-stream discards all stored data.
- Read acceptance: rd_acc = rd & o_valid.
  - rd while o_valid=0 is ignored: no pointer moves, out holds its value.
- Write acceptance, column i: wr_acc_i = wr[i] & (~full_i | rd_acc).
  - A push into a full column in the same cycle as an accepted pop is accepted; the occupancy stays at depth.
- Dropped write (wr[i] & full_i & ~rd_acc): data is discarded, pointers are unchanged, o_overflow is set to 1. It stays 1 until reset.
- Pop: on rd_acc, all columns advance rptr by 1 together. out is loaded with the entry at the old rptr of each column. Data appears on out the cycle after the rd_acc edge and holds until the next rd_acc.
- Simultaneous push and pop on a non-empty column: both occur, occupancy unchanged.
- Push into an empty column: o_valid can rise no earlier than the cycle after the push; there is no write-to-read bypass.
- Pointers wrap modulo 2*depth naturally; data order is strictly FIFO per column.
- Output timing:
  - o_valid, o_full and o_ready are combinational from the registered pointers only, never from rd or wr.
  - o_valid = AND over columns of ~empty_i.
  - o_full = OR over columns of full_i.
- Skew handling: column i may receive its k-th entry up to col-1 cycles after column 0. Row k is readable only once the last column has written its k-th entry.
- No arithmetic on data; psums pass through bit-exact.

Test Plan:
1. Reset and idle: hold reset=0 for 2 cycles, then release with wr=0, rd=0 -> out=0, o_valid=0, o_full=0, o_ready=1, o_overflow=0.
2. Skewed fill and read (col=8): write row values 0x0100+i to column i, asserting wr[i] at cycle t0+i. Assert rd continuously from t0 -> o_valid first rises at t0+8. The cycle after the read, out column i = 0x0100+i. Before t0+8, rd has no effect.
3. FIFO order and wrap: push 3*depth rows in total, all columns together, value = row index. Interleave reads so occupancy stays between 1 and depth-1 -> reads return 0,1,2,… in order across pointer wrap, and o_full never rises.
4. Full and overflow: fill column 3 only, with depth entries -> o_full=1, o_ready=0. One more wr[3] with rd=0 -> data dropped, o_overflow=1. Fill the other columns, then read depth rows -> original depth values are returned and the dropped value never appears.
5. Push and pop at full: all columns full, o_valid=1. Assert rd=1 and wr=all-ones with value 0xBEEF -> both accepted, o_full stays 1, o_overflow stays 0. After depth-1 further reads, 0xBEEF is read out.
6. Reset mid-operation: with 5 rows stored, apply reset=0 while rd=1 and wr=all-ones -> next cycle o_valid=0, out=0, o_overflow=0. A subsequent write followed by a read returns only the new data.
